// File: rtl/aes128_enc_seq_if.sv
// Handshake bundle for the iterative AES-128 encryptor: key/block in, ciphertext out.
interface aes128_enc_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         busy;

  modport master (
    output in_valid, key, block, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, key, block, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/aes128_enc_seq.sv
// Iterative AES-128 encryptor: one cipher round and one key-expansion step per clock.
module aes128_enc_seq (
  input  logic           clk,
  input  logic           rst_n,
  aes128_enc_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    DONE  = 2'b10
  } fsm_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t         fsm;
  logic [127:0] state;
  logic [127:0] rk;
  logic [3:0]   round;
  logic         ready_q;
  logic         valid_q;
  logic         busy_q;

  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] nrk;
  logic [127:0] round_out;

  function automatic logic [7:0] s_box(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s_box(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {s_box(w[31:24]), s_box(w[23:16]), s_box(w[15:8]), s_box(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round datapath; the final round skips MixColumns.
  always_comb begin
    sr        = shift_rows(sub_bytes(state));
    mc        = mix_columns(sr);
    nrk       = key_expand(rk, rcon(round));
    round_out = ((round == 4'd10) ? sr : mc) ^ nrk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      state   <= '0;
      rk      <= '0;
      round   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state   <= bus.block ^ bus.key;
            rk      <= bus.key;
            round   <= 4'd1;
            fsm     <= ROUND;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ROUND: begin
          if (round == 4'd0 || round > 4'd10) begin
            fsm     <= IDLE;
            round   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state <= round_out;
            rk    <= nrk;
            if (round == 4'd10) begin
              fsm     <= DONE;
              valid_q <= 1'b1;
            end else begin
              round <= round + 4'd1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm     <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          fsm     <= IDLE;
          round   <= '0;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Intermediate round values never reach result; only the finished block does.
  assign bus.in_ready  = ready_q & rst_n;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = valid_q ? state : 128'h0;

endmodule
